// File: rtl/if_stage_pkg.sv
// Shared fetch-stage constants: reset PC, RV32I opcode encodings and the
// fetch FSM state encoding.
package if_stage_pkg;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

  localparam logic [6:0] OPC_LOAD     = 7'b0000011;
  localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
  localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
  localparam logic [6:0] OPC_STORE    = 7'b0100011;
  localparam logic [6:0] OPC_OP       = 7'b0110011;
  localparam logic [6:0] OPC_LUI      = 7'b0110111;
  localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
  localparam logic [6:0] OPC_JALR     = 7'b1100111;
  localparam logic [6:0] OPC_JAL      = 7'b1101111;
  localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

  localparam logic [31:0] INSTR_NOP   = 32'h0000_0013;
  localparam logic [31:0] INSTR_ECALL = 32'h0000_0073;

  typedef enum logic [1:0] {
    FETCH_REQ    = 2'd0,
    FETCH_WAIT   = 2'd1,
    FETCH_HALTED = 2'd2
  } fetch_state_e;

  // Sequential fetch address; wraps modulo 2^32 by construction.
  function automatic logic [31:0] pc_next(input logic [31:0] pc);
    return pc + 32'd4;
  endfunction

endpackage

// File: rtl/if_buffer.sv
// One-entry valid/ready output register for fetched instructions, with a
// flush that discards the held entry.
module if_buffer (
  input  logic        clk,
  input  logic        reset,
  input  logic        load,
  input  logic        flush,
  input  logic [31:0] load_pc,
  input  logic [31:0] load_instr,
  input  logic        out_ready,
  output logic        out_valid,
  output logic [31:0] out_pc,
  output logic [31:0] out_instr,
  output logic        can_load
);

  // Free now, or freed by the downstream handshake at this edge.
  assign can_load = !out_valid || out_ready;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_valid <= 1'b0;
      out_pc    <= '0;
      out_instr <= '0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (load) begin
      out_valid <= 1'b1;
      out_pc    <= load_pc;
      out_instr <= load_instr;
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/if_stage.sv
// Instruction fetch stage: single-outstanding request FSM over a valid/ready
// instruction memory port, with redirect, halt and stale-response handling.
module if_stage
  import if_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_resp_valid,
  input  logic [31:0] imem_resp_data,
  output logic        if_valid,
  input  logic        if_ready,
  output logic [31:0] if_pc,
  output logic [31:0] if_instr,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        halt,
  output logic        halted
);

  fetch_state_e state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic         stale_q, stale_d;
  logic         buf_load, buf_flush, buf_can_load;
  logic         req_fire;
  logic [31:0]  redirect_target;
  logic         unused_redirect_lsb;

  assign redirect_target     = {redirect_pc[31:2], 2'b00};
  assign unused_redirect_lsb = ^redirect_pc[1:0];

  // Held low while reset is asserted so the first request appears in the
  // first cycle after release, not during reset.
  assign imem_req_valid = reset && (state_q == FETCH_REQ) && buf_can_load && !halt;
  assign imem_req_addr  = pc_q;
  assign req_fire       = imem_req_valid && imem_req_ready;
  assign halted         = (state_q == FETCH_HALTED);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= FETCH_REQ;
      pc_q    <= RESET_PC;
      stale_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      stale_q <= stale_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    stale_d   = stale_q;
    buf_load  = 1'b0;
    buf_flush = 1'b0;

    unique case (state_q)
      FETCH_REQ: begin
        if (req_fire) begin
          state_d = FETCH_WAIT;
          stale_d = 1'b0;
        end
      end
      FETCH_WAIT: begin
        if (imem_resp_valid) begin
          state_d = FETCH_REQ;
          stale_d = 1'b0;
          if (!stale_q) begin
            buf_load = 1'b1;
            pc_d     = pc_next(pc_q);
          end
        end
      end
      FETCH_HALTED: ;
      default: state_d = FETCH_REQ;
    endcase

    // Halt and redirect override the normal flow; halt takes priority. A
    // redirect that leaves a request in flight marks it stale so its
    // response is dropped.
    if (state_q != FETCH_HALTED) begin
      if (halt) begin
        state_d   = FETCH_HALTED;
        pc_d      = pc_q;
        stale_d   = 1'b0;
        buf_load  = 1'b0;
        buf_flush = 1'b1;
      end else if (redirect_valid) begin
        pc_d      = redirect_target;
        stale_d   = (state_d == FETCH_WAIT);
        buf_load  = 1'b0;
        buf_flush = 1'b1;
      end
    end
  end

  if_buffer u_if_buffer (
    .clk        (clk),
    .reset      (reset),
    .load       (buf_load),
    .flush      (buf_flush),
    .load_pc    (pc_q),
    .load_instr (imem_resp_data),
    .out_ready  (if_ready),
    .out_valid  (if_valid),
    .out_pc     (if_pc),
    .out_instr  (if_instr),
    .can_load   (buf_can_load)
  );

endmodule

// File: tb/tb_if_stage.sv
// Directed self-checking bench for if_stage: fetch cadence, stall, redirect,
// halt, halt+redirect priority and PC wrap from a high reset PC.
module tb_if_stage;

  logic        clk = 1'b0;
  logic        reset = 1'b1;

  logic        imem_req_valid, imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_resp_valid;
  logic [31:0] imem_resp_data;
  logic        if_valid, if_ready;
  logic [31:0] if_pc, if_instr;
  logic        redirect_valid, halt, halted;
  logic [31:0] redirect_pc;

  logic        mem_hold;
  logic        pend;
  logic [31:0] pend_addr;

  logic        req_valid2, resp_valid2, if_valid2, halted2;
  logic [31:0] req_addr2, if_pc2, if_instr2;
  logic        one = 1'b1;
  logic        zero = 1'b0;
  logic [31:0] zero32 = 32'h0;
  logic [31:0] nop32 = 32'h0000_0013;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  if_stage dut (
    .clk             (clk),
    .reset           (reset),
    .imem_req_valid  (imem_req_valid),
    .imem_req_ready  (imem_req_ready),
    .imem_req_addr   (imem_req_addr),
    .imem_resp_valid (imem_resp_valid),
    .imem_resp_data  (imem_resp_data),
    .if_valid        (if_valid),
    .if_ready        (if_ready),
    .if_pc           (if_pc),
    .if_instr        (if_instr),
    .redirect_valid  (redirect_valid),
    .redirect_pc     (redirect_pc),
    .halt            (halt),
    .halted          (halted)
  );

  if_stage #(.RESET_PC(32'hFFFF_FFFC)) dut_wrap (
    .clk             (clk),
    .reset           (reset),
    .imem_req_valid  (req_valid2),
    .imem_req_ready  (one),
    .imem_req_addr   (req_addr2),
    .imem_resp_valid (resp_valid2),
    .imem_resp_data  (nop32),
    .if_valid        (if_valid2),
    .if_ready        (one),
    .if_pc           (if_pc2),
    .if_instr        (if_instr2),
    .redirect_valid  (zero),
    .redirect_pc     (zero32),
    .halt            (zero),
    .halted          (halted2)
  );

  // Memory model: one pending request, answered the cycle after acceptance
  // unless mem_hold delays it. Data encodes the address for traceability.
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      pend      <= 1'b0;
      pend_addr <= '0;
    end else if (imem_req_valid && imem_req_ready) begin
      pend      <= 1'b1;
      pend_addr <= imem_req_addr;
    end else if (pend && !mem_hold) begin
      pend <= 1'b0;
    end
  end
  assign imem_resp_valid = pend && !mem_hold;
  assign imem_resp_data  = 32'h0000_0013 | {pend_addr[19:0], 12'h000};

  always @(posedge clk or negedge reset) begin
    if (!reset) resp_valid2 <= 1'b0;
    else        resp_valid2 <= req_valid2;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    imem_req_ready = 1'b1;
    if_ready       = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    halt           = 1'b0;
    mem_hold       = 1'b0;

    #2 reset = 1'b0;
    step();
    step();
    check("rst_req_valid", {31'b0, imem_req_valid}, 32'd0);
    check("rst_if_valid",  {31'b0, if_valid}, 32'd0);
    check("rst_if_pc",     if_pc, 32'h0);
    check("rst_if_instr",  if_instr, 32'h0);
    check("rst_halted",    {31'b0, halted}, 32'd0);

    // cycle 0: first request right after release
    reset = 1'b1;
    #1;
    check("c0_req_valid", {31'b0, imem_req_valid}, 32'd1);
    check("c0_req_addr",  imem_req_addr, 32'h0);
    check("wrap_c0_addr", req_addr2, 32'hFFFF_FFFC);
    step();
    check("c1_req_valid", {31'b0, imem_req_valid}, 32'd0);
    check("c1_if_valid",  {31'b0, if_valid}, 32'd0);
    step();
    check("c2_if_valid",  {31'b0, if_valid}, 32'd1);
    check("c2_if_pc",     if_pc, 32'h0);
    check("c2_if_instr",  if_instr, 32'h0000_0013);
    check("c2_req_addr",  imem_req_addr, 32'h4);
    check("c2_req_valid", {31'b0, imem_req_valid}, 32'd1);
    check("wrap_c2_addr", req_addr2, 32'h0);
    check("wrap_c2_pc",   if_pc2, 32'hFFFF_FFFC);
    step();
    check("c3_if_valid",  {31'b0, if_valid}, 32'd0);
    step();
    check("c4_if_pc",     if_pc, 32'h4);
    check("c4_if_instr",  if_instr, 32'h0000_4013);
    check("c4_req_addr",  imem_req_addr, 32'h8);

    // decode stall with buffer full
    if_ready = 1'b0;
    #1;
    check("stall_req_drop", {31'b0, imem_req_valid}, 32'd0);
    for (int i = 0; i < 5; i++) begin
      step();
      check("stall_if_valid", {31'b0, if_valid}, 32'd1);
      check("stall_if_pc",    if_pc, 32'h4);
      check("stall_if_instr", if_instr, 32'h0000_4013);
      check("stall_req_valid", {31'b0, imem_req_valid}, 32'd0);
      check("stall_req_addr", imem_req_addr, 32'h8);
    end
    if_ready = 1'b1;
    mem_hold = 1'b1;
    #1;
    check("drain_req_valid", {31'b0, imem_req_valid}, 32'd1);
    step();
    check("wait8_req_valid", {31'b0, imem_req_valid}, 32'd0);
    check("wait8_if_valid",  {31'b0, if_valid}, 32'd0);

    // redirect while waiting on PC 8
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0102;
    step();
    redirect_valid = 1'b0;
    mem_hold       = 1'b0;
    #1;
    check("stale_wait_req", {31'b0, imem_req_valid}, 32'd0);
    step();
    check("stale_if_valid", {31'b0, if_valid}, 32'd0);
    check("redir_req_valid", {31'b0, imem_req_valid}, 32'd1);
    check("redir_req_addr", imem_req_addr, 32'h0000_0100);
    step();
    step();
    check("redir_if_valid", {31'b0, if_valid}, 32'd1);
    check("redir_if_pc",    if_pc, 32'h0000_0100);
    check("redir_if_instr", if_instr, 32'h0010_0013);
    check("redir_next_addr", imem_req_addr, 32'h0000_0104);

    // redirect coincident with an accepted request
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0200;
    step();
    redirect_valid = 1'b0;
    check("redir_req_flush", {31'b0, if_valid}, 32'd0);
    step();
    check("stale2_if_valid", {31'b0, if_valid}, 32'd0);
    check("stale2_req_addr", imem_req_addr, 32'h0000_0200);
    check("stale2_req_valid", {31'b0, imem_req_valid}, 32'd1);

    // halt pulse
    halt = 1'b1;
    #1;
    check("halt_req_drop", {31'b0, imem_req_valid}, 32'd0);
    step();
    halt = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check("halted_flag",   {31'b0, halted}, 32'd1);
      check("halted_req",    {31'b0, imem_req_valid}, 32'd0);
      check("halted_ifv",    {31'b0, if_valid}, 32'd0);
      step();
    end

    // reset out of HALTED, then halt and redirect together
    reset = 1'b0;
    #1;
    check("rst2_halted", {31'b0, halted}, 32'd0);
    check("rst2_req",    {31'b0, imem_req_valid}, 32'd0);
    step();
    reset = 1'b1;
    #1;
    check("rst2_c0_addr", imem_req_addr, 32'h0);
    step();
    step();
    check("rst2_c2_ifv",  {31'b0, if_valid}, 32'd1);
    halt           = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0300;
    step();
    halt           = 1'b0;
    redirect_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check("hr_halted", {31'b0, halted}, 32'd1);
      check("hr_req",    {31'b0, imem_req_valid}, 32'd0);
      check("hr_ifv",    {31'b0, if_valid}, 32'd0);
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/if_stage.md
IF_STAGE -- requirements
Module: if_stage

Interface
REQ-001 RESET_PC, 32'h0000_0000, PC loaded on reset.
REQ-002 clk  in  1  single clock; all state updates on rising edge.
REQ-003 reset  in  1  asynchronous, active-low reset.
REQ-004 imem_req_valid  out  1  fetch request valid.
REQ-005 imem_req_ready  in  1  memory accepts request this cycle.
REQ-006 imem_req_addr  out  32  fetch address, bits[1:0]=0.
REQ-007 imem_resp_valid  in  1  instruction word returned; no earlier than cycle after acceptance.
REQ-008 imem_resp_data  in  32  returned instruction word.
REQ-009 if_valid  out  1  fetched instruction available to decode.
REQ-010 if_ready  in  1  decode accepts instruction this cycle.
REQ-011 if_pc  out  32  PC of if_instr.
REQ-012 if_instr  out  32  instruction to decode/control.
REQ-013 redirect_valid  in  1  taken branch/JAL/JALR from execute.
REQ-014 redirect_pc  in  32  redirect target.
REQ-015 halt  in  1  decode accepted ECALL; stop fetching.
REQ-016 halted  out  1  sticky halt indication.

Function
REQ-017 FSM states SHALL be REQ (drive request), WAIT (one request outstanding), HALTED.
REQ-018 At most one request SHALL be outstanding.
REQ-019 REQ: imem_req_valid=1 only when output buffer empty or draining (if_valid&&if_ready); handshake -> WAIT.
REQ-020 WAIT: on imem_resp_valid, non-stale response SHALL load buffer (if_valid=1, if_instr, if_pc=fetch PC) next edge, PC+=4, -> REQ.
REQ-021 Best-case latency: request accepted cycle N, response N+1, if_valid high N+2.
REQ-022 Buffer SHALL hold if_valid/if_pc/if_instr stable until if_valid&&if_ready.
REQ-023 redirect_valid SHALL clear buffer and load PC with {redirect_pc[31:2],2'b00} next edge, regardless of if_ready.
REQ-024 Redirect in REQ with request handshake same cycle: request SHALL be marked stale; redirect in WAIT: outstanding request marked stale.
REQ-025 Stale response SHALL be discarded (no buffer load, no PC increment); state -> REQ with redirected PC.
REQ-026 Redirect coincident with response: response treated stale.
REQ-027 halt SHALL clear buffer, drop imem_req_valid, set halted, -> HALTED; any outstanding response ignored.
REQ-028 halt and redirect same cycle: halt wins.
REQ-029 HALTED: no requests, if_valid=0, halted=1 until reset.
REQ-030 PC increment SHALL wrap modulo 2^32 (32'hFFFF_FFFC -> 0).

Reset
REQ-031 Reset asserted SHALL immediately force: state=REQ, PC=RESET_PC, if_valid=0, if_pc=0, if_instr=0, halted=0, stale flag=0, imem_req_valid=0.
REQ-032 Reset mid-WAIT SHALL abandon outstanding request; its response after release SHALL be ignored (stale flag set at release only if response may still arrive -- memory is reset together, so none).
REQ-033 First request SHALL be driven in first cycle after reset deasserts.

Structure
REQ-034 Opcode defines, RESET_PC default and FSM state encodings SHALL live in shared opcodes/constants include.
REQ-035 Output buffer SHALL be sub-module if_buffer (1-entry valid/ready register with flush).

Verification
REQ-036 Reset release, 1-cycle memory returning 32'h0000_0013 -> requests at 0,4,8; if_pc 0 at cycle 2, one instruction per 2 cycles.
REQ-037 if_ready=0 for 5 cycles with buffer full -> if_instr/if_pc stable, imem_req_valid=0, no PC advance.
REQ-038 Redirect to 32'h0000_0102 while WAIT at PC 8 -> response for 8 discarded, next request addr 32'h0000_0100.
REQ-039 halt pulse at cycle 10 -> halted=1 cycle 11, imem_req_valid=0 thereafter, if_valid=0.
REQ-040 halt and redirect same cycle -> HALTED, no request to redirect target.
REQ-041 RESET_PC=32'hFFFF_FFFC -> second request addr 32'h0000_0000.
